// File: rtl/jelly3_stream_pipeline_control.sv
// Ready/valid front end for a fixed-latency cke-gated datapath: drives pipe_cke,
// tracks stage valids, and re-streams the result through an output + skid register pair.
module jelly3_stream_pipeline_control #(
    parameter int  LATENCY   = 1,
    parameter int  DATA_BITS = 8,
    parameter type data_t    = logic [DATA_BITS-1:0],
    parameter data_t DATA_INIT = 'x
) (
    input  logic  reset,
    input  logic  clk,
    input  logic  cke,
    input  logic  s_valid,
    output logic  s_ready,
    output logic  pipe_cke,
    output logic  pipe_valid,
    input  data_t pipe_data,
    output data_t m_data,
    output logic  m_valid,
    input  logic  m_ready
);

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } state_t;

    state_t state_q, state_d;
    data_t  mData_q, mData_d;
    data_t  skData_q, skData_d;
    logic   skValid;
    logic   fire;

    assign skValid  = (state_q == TWO);
    assign s_ready  = !reset && !skValid;
    assign pipe_cke = cke && s_ready;
    assign m_valid  = (state_q != EMPTY);
    assign m_data   = mData_q;
    assign fire     = m_valid && m_ready;

    // One valid bit per datapath stage; advances only when the datapath itself advances.
    if (LATENCY == 0) begin : gNoStages
        assign pipe_valid = s_valid && s_ready;
    end else begin : gStages
        logic [LATENCY-1:0] valid_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                valid_q <= '0;
            end else if (pipe_cke) begin
                valid_q <= (valid_q << 1) | LATENCY'(s_valid);
            end
        end

        assign pipe_valid = valid_q[LATENCY-1];
    end

    // The skid is only loaded on an edge where pipe_cke was high, so it catches the
    // single beat that leaves the datapath in the cycle the consumer stalls.
    always_comb begin
        state_d  = state_q;
        mData_d  = mData_q;
        skData_d = skData_q;
        case (state_q)
            EMPTY: begin
                if (pipe_valid) begin
                    mData_d = pipe_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (fire) begin
                    if (pipe_valid) begin
                        mData_d = pipe_data;
                    end else begin
                        state_d = EMPTY;
                    end
                end else if (pipe_valid) begin
                    skData_d = pipe_data;
                    state_d  = TWO;
                end
            end
            TWO: begin
                if (fire) begin
                    mData_d = skData_q;
                    state_d = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= EMPTY;
            mData_q  <= DATA_INIT;
            skData_q <= DATA_INIT;
        end else if (cke) begin
            state_q  <= state_d;
            mData_q  <= mData_d;
            skData_q <= skData_d;
        end
    end

endmodule

// File: tb/tb_jelly3_stream_pipeline_control.sv
// Drives four instances (LATENCY 3, 0, 1, 5) in lockstep, each with its own delay-line
// datapath and expected-value queue filled at accept time and drained at output fire.
module tb_jelly3_stream_pipeline_control;

    localparam int          N    = 4;
    localparam logic [7:0]  INIT = 8'hA5;

    function automatic int latOf(input int k);
        case (k)
            0:       return 3;
            1:       return 0;
            2:       return 1;
            default: return 5;
        endcase
    endfunction

    logic       clk = 1'b0;
    logic       reset;
    logic       cke;
    logic       mReady;
    logic       sValid   [N];
    logic [7:0] sData    [N];
    logic       sReady   [N];
    logic       pipeCke  [N];
    logic       pipeValid[N];
    logic [7:0] pipeData [N];
    logic [7:0] mData    [N];
    logic       mValid   [N];

    logic [7:0] expQ[N][$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         firstAcc[N], firstMv[N], firstFire[N], lastFire[N], popCnt[N], accCnt[N];
    logic       sReadyLow[N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : gInst
        localparam int LAT = latOf(g);

        if (LAT == 0) begin : gComb
            assign pipeData[g] = sData[g];
        end else begin : gDelay
            logic [7:0] dl[LAT];
            always @(posedge clk) begin
                if (pipeCke[g]) begin
                    dl[0] <= sData[g];
                    for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
                end
            end
            assign pipeData[g] = dl[LAT-1];
        end

        jelly3_stream_pipeline_control #(
            .LATENCY  (LAT),
            .DATA_BITS(8),
            .DATA_INIT(INIT)
        ) dut (
            .reset     (reset),
            .clk       (clk),
            .cke       (cke),
            .s_valid   (sValid[g]),
            .s_ready   (sReady[g]),
            .pipe_cke  (pipeCke[g]),
            .pipe_valid(pipeValid[g]),
            .pipe_data (pipeData[g]),
            .m_data    (mData[g]),
            .m_valid   (mValid[g]),
            .m_ready   (mReady)
        );
    end

    task automatic checkOutput(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[inst%0d]: observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic resetStats();
        for (int k = 0; k < N; k++) begin
            firstAcc[k] = -1; firstMv[k] = -1; firstFire[k] = -1; lastFire[k] = -1;
            popCnt[k] = 0; accCnt[k] = 0; sReadyLow[k] = 1'b0;
        end
    endtask

    // One clock: drive at the falling edge, sample just after, then check the effect of the rising edge.
    task automatic applyStimulus(input logic vld, input logic rdy, input logic ck, input logic rst);
        logic       acc[N], hold[N], frz[N], snapV[N], snapR[N];
        logic [7:0] snapD[N];
        logic [7:0] exp;
        reset  = rst;
        cke    = ck;
        mReady = rdy;
        for (int k = 0; k < N; k++) sValid[k] = vld;
        #1;
        for (int k = 0; k < N; k++) begin
            acc[k]  = !rst && ck && sValid[k] && (sReady[k] === 1'b1);
            hold[k] = !rst && ck && (mValid[k] === 1'b1) && !rdy;
            frz[k]  = !rst && !ck;
            snapV[k] = mValid[k];
            snapR[k] = sReady[k];
            snapD[k] = mData[k];
            if (!rst && sReady[k] !== 1'b1) sReadyLow[k] = 1'b1;
            if (!rst && ck && rdy && mValid[k] === 1'b1) begin
                checks++;
                assert (expQ[k].size() != 0) else begin
                    errors++;
                    $error("FAIL unexpectedOutput[inst%0d]: observed=%0h expected=none", k, mData[k]);
                end
                if (expQ[k].size() != 0) begin
                    exp = expQ[k].pop_front();
                    checkOutput("mData", k, 32'(mData[k]), 32'(exp));
                end
                popCnt[k]++;
                if (firstFire[k] < 0) firstFire[k] = cyc;
                lastFire[k] = cyc;
            end
            if (acc[k]) begin
                if (firstAcc[k] < 0) firstAcc[k] = cyc;
                accCnt[k]++;
            end
            if (mValid[k] === 1'b1 && firstAcc[k] >= 0 && firstMv[k] < 0) firstMv[k] = cyc;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            if (rst) expQ[k].delete();
            if (acc[k]) begin
                expQ[k].push_back(sData[k]);
                sData[k] = sData[k] + 8'd1;
            end
            if (hold[k]) begin
                checkOutput("holdValid", k, 32'(mValid[k]), 32'd1);
                checkOutput("holdData", k, 32'(mData[k]), 32'(snapD[k]));
            end
            if (frz[k]) begin
                checkOutput("ckeFrozenValid", k, 32'(mValid[k]), 32'(snapV[k]));
                checkOutput("ckeFrozenReady", k, 32'(sReady[k]), 32'(snapR[k]));
                checkOutput("ckeFrozenData", k, 32'(mData[k]), 32'(snapD[k]));
            end
        end
    endtask

    task automatic drain(input int n);
        for (int c = 0; c < n; c++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < N; k++) checkOutput("drainEmpty", k, expQ[k].size(), 32'd0);
    endtask

    initial begin
        logic allDone;
        logic r0, c0;
        reset  = 1'b1;
        cke    = 1'b1;
        mReady = 1'b1;
        for (int k = 0; k < N; k++) begin
            sValid[k] = 1'b0;
            sData[k]  = 8'd1;
        end
        resetStats();
        @(negedge clk);

        // Reset behaviour
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < N; k++) begin
            checkOutput("resetSReady", k, 32'(sReady[k]), 32'd0);
            checkOutput("resetPipeCke", k, 32'(pipeCke[k]), 32'd0);
            checkOutput("resetMValid", k, 32'(mValid[k]), 32'd0);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < N; k++) begin
            checkOutput("initMData", k, 32'(mData[k]), 32'(INIT));
            checkOutput("initSReady", k, 32'(sReady[k]), 32'd1);
        end

        // Values 1..16 streamed with no backpressure
        resetStats();
        for (int c = 0; c < 16; c++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        drain(12);
        for (int k = 0; k < N; k++) begin
            checkOutput("latency", k, firstMv[k] - firstAcc[k], latOf(k) + 1);
            checkOutput("outCount", k, popCnt[k], 32'd16);
            checkOutput("throughput", k, lastFire[k] - firstFire[k], 32'd15);
            checkOutput("sReadyAlways", k, 32'(sReadyLow[k]), 32'd0);
        end

        // Backpressure burst: skid fills one cycle after m_ready drops
        for (int c = 0; c < 21; c++) begin
            applyStimulus(1'b1, !(c >= 6 && c <= 10), 1'b1, 1'b0);
            if (c == 6) begin
                for (int k = 0; k < N; k++) begin
                    checkOutput("stallSReady", k, 32'(sReady[k]), 32'd0);
                    checkOutput("stallPipeCke", k, 32'(pipeCke[k]), 32'd0);
                end
            end
            if (c == 8) begin
                r0 = sReady[0];
                c0 = pipeCke[0];
                mReady = 1'b1;
                #1;
                checkOutput("sReadyIndepOfMReady", 0, 32'(sReady[0]), 32'(r0));
                checkOutput("pipeCkeIndepOfMReady", 0, 32'(pipeCke[0]), 32'(c0));
                mReady = 1'b0;
                #1;
            end
        end
        drain(12);

        // Alternating cke while stalled
        for (int c = 0; c < 25; c++)
            applyStimulus(1'b1, !(c >= 6 && c <= 12), !(c >= 4 && c <= 16 && (c % 2) == 1), 1'b0);
        drain(12);

        // Random valid 50% / ready 30%
        resetStats();
        allDone = 1'b0;
        for (int c = 0; c < 12000 && !allDone; c++) begin
            applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 3), 1'b1, 1'b0);
            allDone = 1'b1;
            for (int k = 0; k < N; k++) if (accCnt[k] < 1000) allDone = 1'b0;
        end
        for (int k = 0; k < N; k++) checkOutput("randomBeats", k, 32'(accCnt[k] >= 1000), 32'd1);
        drain(12);

        // Reset while skid is full and beats are in flight
        allDone = 1'b0;
        for (int c = 0; c < 20 && !allDone; c++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
            allDone = 1'b1;
            for (int k = 0; k < N; k++) if (sReady[k] !== 1'b0) allDone = 1'b0;
        end
        for (int k = 0; k < N; k++) checkOutput("fullBeforeReset", k, 32'(sReady[k]), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        reset = 1'b0;
        for (int k = 0; k < N; k++) sValid[k] = 1'b0;
        #1;
        for (int k = 0; k < N; k++) begin
            checkOutput("midResetMValid", k, 32'(mValid[k]), 32'd0);
            checkOutput("midResetSReady", k, 32'(sReady[k]), 32'd1);
            checkOutput("midResetMData", k, 32'(mData[k]), 32'(INIT));
            checkOutput("midResetPipeValid", k, 32'(pipeValid[k]), 32'd0);
            sData[k] = 8'd100;
        end
        resetStats();
        for (int c = 0; c < 4; c++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        drain(12);
        for (int k = 0; k < N; k++) checkOutput("postResetCount", k, popCnt[k], 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jelly3_stream_pipeline_control.md
Name: jelly3_stream_pipeline_control

Overview:
Bridges a ready/valid stream onto fixed-latency cke-gated datapath stages built from jelly3_data_delay and similar pipelines. The block sits directly upstream of that datapath, driving its clock enable and tracking which stages hold valid data. It then collects the datapath result and presents it as a ready/valid stream. A skid register makes s_ready and pipe_cke depend only on flops and cke, never on m_ready.

Parameters:
LATENCY, 1, cycles from pipe_cke-qualified input to pipe_data in the external datapath; 0 is allowed.
DATA_BITS, 8, result width.
data_t, logic [DATA_BITS-1:0], result type.
DATA_INIT, 'x, reset value of m_data and the skid data register.

Ports:
reset  input  1  synchronous, active-high reset
clk  input  1  clock
cke  input  1  global clock enable; when 0, all state holds and no handshake completes
s_valid  input  1  upstream data valid
s_ready  output  1  upstream accept
pipe_cke  output  1  clock enable for the external datapath
pipe_valid  output  1  valid of the last tracked stage, aligned with pipe_data
pipe_data  input  data_t  datapath output, LATENCY pipe_cke-edges after its input
m_data  output  data_t  result data
m_valid  output  1  result valid
m_ready  input  1  downstream accept

Behaviour:
- pipe_cke = cke & !reset & !sk_valid.
- s_ready = !reset & !sk_valid. A transfer needs cke & s_valid & s_ready.
- Valid shift register v[0..LATENCY-1]:
  - On clk with pipe_cke: v[0] <= s_valid, v[i] <= v[i-1].
  - Bubbles (s_valid=0) shift through as zeros.
  - pipe_valid = v[LATENCY-1].
  - LATENCY=0: no register; pipe_valid = s_valid & s_ready, and pipe_data is the same-cycle input.
- Output register (m_valid/m_data) plus skid register (sk_valid/sk_data). Buffer states:
  - EMPTY (!m_valid, !sk_valid)
  - ONE (m_valid, !sk_valid)
  - TWO (m_valid, sk_valid)
- Per clk edge with cke=1, with fire = m_valid & m_ready:
  - EMPTY: if pipe_valid, m <= pipe_data -> ONE.
  - ONE & fire: m_valid <= pipe_valid, m_data <= pipe_data when pipe_valid; stay ONE or go to EMPTY.
  - ONE & !fire: if pipe_valid, sk <= pipe_data -> TWO; else stay ONE.
  - TWO: pipe_cke=0, so the pipeline is frozen. On fire, m <= sk and sk_valid <= 0 -> ONE; else hold.
- TWO is only entered on an edge where pipe_cke=1. The skid never overflows, and at most one item is in flight beyond the pipeline.
- With cke=0: no register changes and m_ready is ignored. m_valid/m_data are held and must stay stable.
- Latency: accepted beat to m_valid is LATENCY+1 cke-cycles when there is no stall.
- Throughput: 1 beat/cycle while m_ready=1.
- After m_ready drops, the pipeline freezes one cycle later, once the skid is filled. Any beat accepted in that cycle stays in the pipeline; none is lost.
- Ordering is strictly preserved. No data is dropped or duplicated.
- Reset (sync, any time, including mid-stall):
  - v all 0, m_valid=0, sk_valid=0, m_data=sk_data=DATA_INIT.
  - s_ready=0 and pipe_cke=0 while reset is high.
  - In-flight beats are discarded. The external datapath is not reset by this block.
- m_valid never deasserts without fire or reset. m_data stays stable while m_valid & !m_ready.

Test Plan:
- LATENCY=3, data_delay as datapath, values 1..16 streamed, m_ready=1 -> m outputs 1..16 in order, first m_valid 4 cycles after the first accept, one per cycle, s_ready always 1.
- LATENCY=3, m_ready=0 for cycles 6-10 mid-stream -> skid fills (s_ready=0 and pipe_cke=0 from cycle 7), m_data is held stable, then the stream resumes with no loss or duplicate.
- Random s_valid 50% / m_ready 30% with LATENCY in {0,1,5}, 1000 beats -> scoreboard exact match; s_ready never depends combinationally on m_ready.
- cke toggled 0 on alternate cycles during a stall -> state frozen on cke=0 cycles; output sequence identical to the cke=1 run.
- Reset asserted for 1 cycle while in state TWO with 3 beats in flight -> next cycle m_valid=0, s_ready=1, m_data=DATA_INIT; post-reset beats 100..103 emerge correctly.
- LATENCY=0 -> m_valid rises 1 cycle after accept; a backpressure burst behaves as in the second scenario.
